// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: opcodes, FSM encoding, flag bit positions.
package alu_arbiter_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] ADD  = 4'b0000;
    localparam logic [OP_W-1:0] SLL  = 4'b0001;
    localparam logic [OP_W-1:0] SLT  = 4'b0010;
    localparam logic [OP_W-1:0] SLTU = 4'b0011;
    localparam logic [OP_W-1:0] XOR  = 4'b0100;
    localparam logic [OP_W-1:0] SRL  = 4'b0101;
    localparam logic [OP_W-1:0] OR   = 4'b0110;
    localparam logic [OP_W-1:0] AND  = 4'b0111;
    localparam logic [OP_W-1:0] SUB  = 4'b1000;
    localparam logic [OP_W-1:0] SRA  = 4'b1101;

    localparam int unsigned ZF = 3;
    localparam int unsigned CF = 2;
    localparam int unsigned OF = 1;
    localparam int unsigned SF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Combinational ALU shared by both requesters; the arbiter registers everything.
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] f,
    output logic              zf,
    output logic              cf,
    output logic              of,
    output logic              sf
);

    localparam int unsigned MSB  = DATA_W - 1;
    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic              shift_ovf;
    logic [SH_W-1:0]   shamt;

    // Result and flags; shift amounts beyond the word width saturate
    always_comb begin
        sum       = {1'b0, x} + {1'b0, y};
        diff      = x - y;
        shift_ovf = (y >= DATA_W'(DATA_W));
        shamt     = y[SH_W-1:0];
        f         = '0;
        cf        = 1'b0;
        of        = 1'b0;
        case (op)
            ADD: begin
                f  = sum[DATA_W-1:0];
                cf = sum[DATA_W];
                of = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
            end
            SUB: begin
                f  = diff;
                cf = (x < y);
                of = (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]);
            end
            SLL:  f = shift_ovf ? '0 : (x << shamt);
            SRL:  f = shift_ovf ? '0 : (x >> shamt);
            SRA:  f = shift_ovf ? {DATA_W{x[MSB]}} : DATA_W'($signed(x) >>> shamt);
            SLT:  f = DATA_W'($signed(x) < $signed(y));
            SLTU: f = DATA_W'(x < y);
            XOR:  f = x ^ y;
            OR:   f = x | y;
            AND:  f = x & y;
            default: f = '0;
        endcase
        zf = (f == '0);
        sf = f[MSB];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// Macro ALU_ARB_RR_EN: round-robin on ties (default build: requester 0 always wins ties).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] imm0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] imm1,
    input  logic              sel_imm0,
    input  logic              sel_imm1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] res,
    output logic [FLAG_W-1:0] fr,
    output logic              busy
);

`ifdef ALU_ARB_RR_EN
    // Pointer starts at requester 1 so requester 0 takes the first tie
    localparam logic WIN_RST = 1'b1;
`else
    localparam logic WIN_RST = 1'b0;
`endif

    state_t            state, next_state;
    logic              win, next_win;
    logic              gnt0_d, gnt1_d, done0_d, done1_d, busy_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] x_q, y_q;
    logic [DATA_W-1:0] alu_f;
    logic              alu_zf, alu_cf, alu_of, alu_sf;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .x  (x_q),
        .y  (y_q),
        .f  (alu_f),
        .zf (alu_zf),
        .cf (alu_cf),
        .of (alu_of),
        .sf (alu_sf)
    );

    // Next state, arbitration and next values of the registered outputs
    always_comb begin
        next_state = state;
        next_win   = win;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        busy_d     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_state = LOAD;
`ifdef ALU_ARB_RR_EN
                    next_win = (req0 && req1) ? ~win : req1;
`else
                    next_win = ~req0;
`endif
                end
            end
            LOAD:    next_state = EXEC;
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        gnt0_d  = (next_state == LOAD) && !next_win;
        gnt1_d  = (next_state == LOAD) &&  next_win;
        done0_d = (next_state == DONE) && !next_win;
        done1_d = (next_state == DONE) &&  next_win;
        busy_d  = (next_state != IDLE);
    end

    // Control state and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            win   <= WIN_RST;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            win   <= next_win;
            gnt0  <= gnt0_d;
            gnt1  <= gnt1_d;
            done0 <= done0_d;
            done1 <= done1_d;
            busy  <= busy_d;
        end
    end

    // Operand capture in LOAD, result/flag capture in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            res  <= '0;
            fr   <= '0;
        end else begin
            if (state == LOAD) begin
                op_q <= win ? op1 : op0;
                x_q  <= win ? a1 : a0;
                y_q  <= win ? (sel_imm1 ? imm1 : b1) : (sel_imm0 ? imm0 : b0);
            end
            if (state == EXEC) begin
                res    <= alu_f;
                fr[ZF] <= alu_zf;
                fr[CF] <= alu_cf;
                fr[OF] <= alu_of;
                fr[SF] <= alu_sf;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, imm0, a1, b1, imm1;
    logic        sel_imm0, sel_imm1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [31:0] res;
    logic [3:0]  fr;

    int n_tests = 0;
    int n_fail  = 0;
`ifdef ALU_ARB_RR_EN
    int last_win = 1;
`endif

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .imm0(imm0),
        .a1(a1), .b1(b1), .imm1(imm1),
        .sel_imm0(sel_imm0), .sel_imm1(sel_imm1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .fr(fr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU written with wide signed/unsigned arithmetic
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] fl);
        longint     sx, sy, s;
        logic [63:0] u;
        logic       c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c = 1'b0;
        o = 1'b0;
        r = 32'd0;
        case (op)
            4'h0: begin
                u = 64'(x) + 64'(y);
                r = u[31:0];
                c = u[32];
                s = sx + sy;
                o = (s > MAX_S) || (s < MIN_S);
            end
            4'h8: begin
                r = x - y;
                c = (x < y);
                s = sx - sy;
                o = (s > MAX_S) || (s < MIN_S);
            end
            4'h1: r = (y >= 32) ? 32'd0 : (x << y);
            4'h5: r = (y >= 32) ? 32'd0 : (x >> y);
            4'hD: begin
                if (y >= 32) r = x[31] ? 32'hFFFF_FFFF : 32'd0;
                else         r = 32'(sx >>> y);
            end
            4'h2: r = (sx < sy) ? 32'd1 : 32'd0;
            4'h3: r = (x < y) ? 32'd1 : 32'd0;
            4'h4: r = x ^ y;
            4'h6: r = x | y;
            4'h7: r = x & y;
            default: r = 32'd0;
        endcase
        fl = {(r == 32'd0), c, o, r[31]};
    endfunction

    // Expected winner given the current request lines
    function automatic int pick(input logic q0, input logic q1);
`ifdef ALU_ARB_RR_EN
        if (q0 && q1) return 1 - last_win;
`else
        if (q0 && q1) return 0;
`endif
        return q0 ? 0 : 1;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 40));
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Follow one operation from grant to done and check it
    task automatic serve(input bit drop, input bit scramble, input bit chk_lat, output int w);
        int          n;
        bit          got;
        logic [3:0]  eop;
        logic [31:0] ex, ey, er;
        logic [3:0]  ef;
        w = pick(req0, req1);
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (gnt0 || gnt1) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        if (chk_lat) chk("gnt_latency", 32'(n), 32'd1);
`ifdef ALU_ARB_RR_EN
        last_win = w;
`endif
        if (w == 0) begin eop = op0; ex = a0; ey = sel_imm0 ? imm0 : b0; end
        else        begin eop = op1; ex = a1; ey = sel_imm1 ? imm1 : b1; end
        ref_alu(eop, ex, ey, er, ef);
        if (drop) begin
            if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("gnt_pulse", 32'(gnt0 | gnt1), 32'd0);
        chk("exec_nodone", 32'(done0 | done1), 32'd0);
        if (scramble) begin
            if (w == 0) begin op0 = ~op0; a0 = ~a0; b0 = $urandom; imm0 = $urandom; sel_imm0 = ~sel_imm0; end
            else        begin op1 = ~op1; a1 = ~a1; b1 = $urandom; imm1 = $urandom; sel_imm1 = ~sel_imm1; end
        end
        @(negedge clk);
        chk("done0", 32'(done0), 32'(w == 0));
        chk("done1", 32'(done1), 32'(w == 1));
        chk("res", res, er);
        chk("fr", 32'(fr), 32'(ef));
    endtask

    // One request from an idle arbiter, checked against literal expectations
    task automatic single(input string tag, input int who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic sel,
                          input logic [31:0] exp_res, input logic [3:0] exp_fr);
        int w;
        @(negedge clk);
        if (who == 0) begin op0 = op; a0 = a; b0 = b; imm0 = imm; sel_imm0 = sel; req0 = 1'b1; end
        else          begin op1 = op; a1 = a; b1 = b; imm1 = imm; sel_imm1 = sel; req1 = 1'b1; end
        serve(1'b0, 1'b0, 1'b1, w);
        req0 = 1'b0;
        req1 = 1'b0;
        chk({tag, "_who"}, 32'(w), 32'(who));
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_fr"}, 32'(fr), 32'(exp_fr));
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, res, exp_res);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        int exp_order[3];
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 4'h0; op1 = 4'h0;
        a0 = '0; b0 = '0; imm0 = '0; a1 = '0; b1 = '0; imm1 = '0;
        sel_imm0 = 1'b0; sel_imm1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_fr", 32'(fr), 32'd0);
        rst = 1'b0;

        single("add_5_7",  0, 4'h0, 32'd5, 32'd7, 32'd0, 1'b0, 32'd12, 4'b0000);
        single("sub_3_5",  0, 4'h8, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFE, 4'b0101);
        single("add_ovf",  1, 4'h0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h8000_0000, 4'b0011);
        single("add_cry",  0, 4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 4'b1100);
        single("undef",    0, 4'hF, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0, 4'b1000);
        single("sra_imm",  1, 4'hD, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'hF800_0000, 4'b0001);
        single("sra_40",   0, 4'hD, 32'h8000_0000, 32'd40, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b0001);

        // Reset during EXEC aborts the operation
        @(negedge clk);
        op0 = 4'h0; a0 = 32'd1; b0 = 32'd1; sel_imm0 = 1'b0; req0 = 1'b1;
        n = 0;
        while (!gnt0 && n < 8) begin @(negedge clk); n++; end
        chk("abort_gnt", 32'(gnt0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_fr", 32'(fr), 32'd0);
        @(negedge clk);
        chk("abort_done", 32'(done0 | done1), 32'd0);
        rst = 1'b0;
`ifdef ALU_ARB_RR_EN
        last_win = 1;
`endif
        repeat (4) begin
            @(negedge clk);
            chk("abort_quiet", 32'(done0 | done1 | busy), 32'd0);
        end

        // Request dropped right after grant still completes
        @(negedge clk);
        op0 = 4'h4; a0 = 32'hF0F0_0000; b0 = 32'h0F0F_1234; sel_imm0 = 1'b0; req0 = 1'b1;
        serve(1'b1, 1'b0, 1'b1, w);
        chk("drop_res", res, 32'hFFFF_1234);

        // Operands changed after LOAD do not disturb the result
        @(negedge clk);
        op1 = 4'h7; a1 = 32'hFF00_FF00; imm1 = 32'h0FF0_0FF0; sel_imm1 = 1'b1; req1 = 1'b1;
        serve(1'b0, 1'b1, 1'b1, w);
        req1 = 1'b0;
        chk("scr_res", res, 32'h0F00_0F00);

        // Simultaneous requests over three back-to-back operations
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        @(negedge clk);
        op0 = 4'h0; a0 = 32'd100; b0 = 32'd1; sel_imm0 = 1'b0;
        op1 = 4'h8; a1 = 32'd100; b1 = 32'd1; sel_imm1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            serve(1'b0, 1'b0, k == 0, w);
            chk("tie_order", 32'(w), 32'(exp_order[k]));
        end
        req0 = 1'b0;
        serve(1'b0, 1'b0, 1'b0, w);
        chk("tie_last", 32'(w), 32'd1);
        req1 = 1'b0;

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            int p;
            @(negedge clk);
            p = $urandom_range(1, 3);
            op0 = 4'($urandom); a0 = rnd_val(); b0 = rnd_val(); imm0 = rnd_val(); sel_imm0 = 1'($urandom);
            op1 = 4'($urandom); a1 = rnd_val(); b1 = rnd_val(); imm1 = rnd_val(); sel_imm1 = 1'($urandom);
            req0 = p[0];
            req1 = p[1];
            serve(1'b1, 1'b0, 1'b1, w);
            if (req0 || req1) serve(1'b1, 1'b0, 1'b0, w);
            req0 = 1'b0;
            req1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  single clock; every register updates on its rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: req0 / req1  in  1  request from requester 0/1; held high until that requester's done.
REQ-005 Port: op0 / op1  in  4  ALU opcode per requester.
REQ-006 Port: a0, b0, imm0 / a1, b1, imm1  in  32 each  first operand, second operand and immediate per requester.
REQ-007 Port: sel_imm0 / sel_imm1  in  1  1 selects imm, 0 selects b, as the second operand.
REQ-008 Port: gnt0 / gnt1  out  1  one-cycle pulse: request accepted and operands captured.
REQ-009 Port: done0 / done1  out  1  one-cycle pulse: res and fr valid for that requester.
REQ-010 Port: res  out  32  result of the last completed operation; held until the next done.
REQ-011 Port: fr  out  4  flags {ZF,CF,OF,SF} of the last completed operation; held until the next done.
REQ-012 Port: busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE -> LOAD -> EXEC -> DONE -> IDLE.
REQ-014 IDLE: if any req is high, arbitrate, record the winner and go to LOAD; otherwise stay in IDLE.
REQ-015 LOAD: capture the winner's op and operand A, plus b or imm according to sel_imm, into internal registers; pulse the winner's gnt.
REQ-016 EXEC: compute from the captured registers only; register the result and flags into res and fr.
REQ-017 DONE: pulse the winner's done for one cycle.
REQ-018 Latency: the rising edge on which req is sampled in IDLE (edge 0) leads to gnt high in the following cycle; done is high in the third cycle after edge 0.
REQ-019 Throughput: one operation per 4 cycles; a req still high in DONE is arbitrated on the next IDLE cycle.
REQ-020 Opcodes, with X = captured A and Y = captured second operand:
- 0000 add
- 0001 sll X<<Y
- 0010 signed set-less-than
- 0011 unsigned set-less-than
- 0100 xor
- 0101 srl
- 0110 or
- 0111 and
- 1000 sub
- 1101 sra
- any other opcode gives res = 0
REQ-021 Shifts use the full 32-bit Y: Y >= 32 gives 0 for sll/srl and 32 copies of X[31] for sra.
REQ-022 ZF = (res == 0).
REQ-023 SF = res[31].
REQ-024 CF: carry-out of the 33-bit add; for sub, the borrow (X < Y unsigned); 0 for every other opcode.
REQ-025 OF: signed overflow for add/sub; 0 for every other opcode.
REQ-026 A requester dropping req after gnt does not abort: the operation completes and done still pulses.
REQ-027 Input changes after LOAD do not affect the result.
REQ-028 gnt0/gnt1 and done0/done1 are never high in the same cycle.

Reset
REQ-029 Reset state: FSM in IDLE; gnt0, gnt1, done0, done1 and busy = 0; res = 0; fr = 0; operand and op registers = 0; last-winner pointer = requester 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-operation aborts the operation: no done is issued and the state above is restored immediately.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the requester that did not win last gets the grant.
REQ-032 Macro ALU_ARB_RR_EN undefined: fixed priority; requester 0 always wins ties and the last-winner pointer is not implemented.

Structure
REQ-033 A shared package holds: the 4-bit opcode localparams (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA), the FSM state encoding, and the flag bit indices (ZF=3, CF=2, OF=1, SF=0).
REQ-034 Sub-module alu_core: the combinational ALU (op, x, y -> f, zf, cf, of, sf), instantiated once; the arbiter owns all registers.

Verification
REQ-035 Single request: req0, op=0000, a0=5, b0=7, sel_imm0=0 -> gnt0 one cycle later, done0 two cycles after that, res=12, fr=0000.
REQ-036 Simultaneous requests: req0 and req1 asserted together, ALU_ARB_RR_EN defined -> grant order 0, 1, 0 over three back-to-back operations. Same test with the macro undefined -> requester 0 wins every tie.
REQ-037 Flag and shift cases:
- sub a=3, b=5 -> res=0xFFFFFFFE, fr=0101 (CF=1, SF=1)
- add 0x7FFFFFFF + 1 -> fr=0011 (OF=1, SF=1)
- add 0xFFFFFFFF + 1 -> res=0, fr=1100 (ZF=1, CF=1)
REQ-038 Immediate and shift select: sel_imm1=1, op=1101, a1=0x80000000, imm1=4, b1=0 -> res=0xF8000000. sra with Y=40 -> res=0xFFFFFFFF.
REQ-039 Abort and robustness:
- rst pulsed during EXEC -> no done; res=0, fr=0, busy=0.
- req0 dropped right after gnt0 -> done0 still pulses.
- operands changed after gnt -> result unchanged.
REQ-040 Undefined opcode 1111 with a=b=9 -> res=0, fr=1000.
